// File: rtl/csr_commit_queue.sv
// Multi-lane CSR commit buffer: compacts live commit lanes into an in-order FIFO,
// coalesces consecutive fflag-only records and drains one record per cycle.
module csr_commit_queue #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [CHANNELS-1:0]      in_valid_i,
    input  logic [CHANNELS*XLEN-1:0] in_csrdata_i,
    input  logic [CHANNELS*12-1:0]   in_csrindex_i,
    input  logic [CHANNELS-1:0]      in_csren_i,
    input  logic [CHANNELS-1:0]      in_mret_i,
    input  logic [CHANNELS-1:0]      in_sret_i,
    input  logic [CHANNELS*5-1:0]    in_fflag_i,
    input  logic [CHANNELS-1:0]      in_fflagen_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    output logic [XLEN-1:0]          out_csrdata_o,
    output logic [11:0]              out_csrindex_o,
    output logic                     out_csren_o,
    output logic                     out_mret_o,
    output logic                     out_sret_o,
    output logic                     out_fflagen_o,
    output logic [4:0]               out_fflag_o,
    input  logic                     out_ready_i,
    output logic                     empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            valid;
        logic            csren;
        logic            mret;
        logic            sret;
        logic            fflagen;
        logic [4:0]      fflag;
        logic [11:0]     index;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   alloc;
    logic [PW-1:0]   prev_slot;
    logic            prev_ff;
    logic            pop;
    logic            live;
    logic            rec_ff;
    entry_t          rec;
    entry_t          head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
    endfunction

    function automatic logic fflag_only(input entry_t e);
        return e.fflagen & ~e.csren & ~e.mret & ~e.sret;
    endfunction

    assign head        = mem_q[rptr_q];
    assign in_ready_o  = (count_q <= CW'(DEPTH - CHANNELS));
    assign empty_o     = (count_q == '0);
    assign out_valid_o = head.valid;

    // Idle fields read as zero so a stale slot never leaks onto the bus
    always_comb begin
        out_csrdata_o  = '0;
        out_csrindex_o = '0;
        out_csren_o    = 1'b0;
        out_mret_o     = 1'b0;
        out_sret_o     = 1'b0;
        out_fflagen_o  = 1'b0;
        out_fflag_o    = '0;
        if (head.valid) begin
            out_csrdata_o  = head.data;
            out_csrindex_o = head.index;
            out_csren_o    = head.csren;
            out_mret_o     = head.mret;
            out_sret_o     = head.sret;
            out_fflagen_o  = head.fflagen;
            out_fflag_o    = head.fflag;
        end
    end

    // Pop head, then walk lanes oldest-first, merging fflag-only records into the previous one
    always_comb begin
        mem_d     = mem_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        alloc     = '0;
        live      = 1'b0;
        rec_ff    = 1'b0;
        rec       = '0;
        pop       = head.valid & out_ready_i;
        prev_slot = ptr_dec(wptr_q);
        // The tail is off-limits for merging when it is the head leaving this cycle
        prev_ff   = (count_q != '0) && fflag_only(mem_q[prev_slot])
                    && !(pop && (count_q == CW'(1)));

        if (pop) begin
            mem_d[rptr_q].valid = 1'b0;
            rptr_d              = ptr_inc(rptr_q);
        end

        for (int l = 0; l < int'(CHANNELS); l++) begin
            rec.valid   = 1'b1;
            rec.csren   = in_csren_i[l];
            rec.mret    = in_mret_i[l];
            rec.sret    = in_sret_i[l] & ~in_mret_i[l];
            rec.fflagen = in_fflagen_i[l];
            rec.fflag   = in_fflag_i[l*5 +: 5];
            rec.index   = in_csrindex_i[l*12 +: 12];
            rec.data    = in_csrdata_i[l*XLEN +: XLEN];
            rec_ff      = fflag_only(rec);
            live        = in_valid_i[l] & in_ready_o
                          & (rec.csren | rec.mret | rec.sret | rec.fflagen);
            if (live) begin
                if (rec_ff && prev_ff) begin
                    mem_d[prev_slot].fflag = mem_d[prev_slot].fflag | rec.fflag;
                end else begin
                    mem_d[wptr_d] = rec;
                    prev_slot     = wptr_d;
                    wptr_d        = ptr_inc(wptr_d);
                    alloc         = alloc + CW'(1);
                    prev_ff       = rec_ff;
                end
            end
        end

        count_d = count_q + alloc - CW'(pop);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
